// File: rtl/conv_window_ctrl_if.sv
// Pixel-stream handshake between the upstream pixel source (master) and the
// window controller (slave).
interface conv_window_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] pixel_in;

    modport master (
        output in_valid,
        output pixel_in,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  pixel_in,
        output in_ready
    );
endinterface

// File: rtl/conv_window_ctrl.sv
// Frame sequencer feeding a 3x3 window collector: one pixel per clock, flags valid windows.
// Optional macro CONV_WINDOW_STRIDE2_EN adds cfg_stride2 (only odd-centred windows flagged).
module conv_window_ctrl #(
    parameter int IMAGE_WIDTH  = 128,
    parameter int IMAGE_HEIGHT = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [7:0]          cfg_width,
    input  logic [7:0]          cfg_height,
`ifdef CONV_WINDOW_STRIDE2_EN
    input  logic                cfg_stride2,
`endif
    conv_window_ctrl_if.slave   pix_if,
    output logic [7:0]          pix_out,
    output logic [7:0]          stage_width,
    output logic                win_valid,
    output logic                win_last,
    output logic [7:0]          win_row,
    output logic [7:0]          win_col,
    output logic                busy,
    output logic                done,
    output logic                underrun,
    output logic                cfg_err
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    logic [0:0] r_state;
    logic [7:0] r_w;
    logic [7:0] r_h;
    logic [7:0] r_row;
    logic [7:0] r_col;
    logic [7:0] r_stage_width;
    logic [7:0] r_win_row;
    logic [7:0] r_win_col;
    logic       r_win_valid;
    logic       r_win_last;
    logic       r_underrun;
    logic       r_cfg_err;
    logic       w_stride2;

    logic w_streaming;
    logic w_cfg_ok;
    logic w_col_last;
    logic w_row_last;
    logic w_win_hit;
    logic w_stride_ok;

    assign w_streaming = (r_state == ST_STREAM);
    assign w_cfg_ok    = (cfg_width  >= 8'd3) && (32'(cfg_width)  <= 32'(IMAGE_WIDTH)) &&
                         (cfg_height >= 8'd3) && (32'(cfg_height) <= 32'(IMAGE_HEIGHT));
    assign w_col_last  = (r_col == r_w - 8'd1);
    assign w_row_last  = (r_row == r_h - 8'd1);
    // Windows touching rows/cols 0..1 straddle stale line-buffer data.
    assign w_win_hit   = (r_row >= 8'd2) && (r_col >= 8'd2);
    // Centre = (r-1, c-1), so an odd centre means even counters.
    assign w_stride_ok = !w_stride2 || (!r_row[0] && !r_col[0]);

`ifdef CONV_WINDOW_STRIDE2_EN
    logic r_stride2;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stride2 <= 1'b0;
        end else if (!w_streaming && start && w_cfg_ok) begin
            r_stride2 <= cfg_stride2;
        end
    end
    assign w_stride2 = r_stride2;
`else
    assign w_stride2 = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_w           <= 8'd0;
            r_h           <= 8'd0;
            r_row         <= 8'd0;
            r_col         <= 8'd0;
            r_stage_width <= 8'(IMAGE_WIDTH);
            r_win_row     <= 8'd0;
            r_win_col     <= 8'd0;
            r_win_valid   <= 1'b0;
            r_win_last    <= 1'b0;
            r_underrun    <= 1'b0;
            r_cfg_err     <= 1'b0;
        end else begin
            r_win_valid <= 1'b0;
            r_win_last  <= 1'b0;
            if (w_streaming) begin
                if (!pix_if.in_valid) begin
                    r_underrun <= 1'b1;
                end
                r_win_valid <= w_win_hit && w_stride_ok;
                if (w_win_hit) begin
                    r_win_row <= r_row - 8'd1;
                    r_win_col <= r_col - 8'd1;
                end
                if (w_col_last) begin
                    r_col <= 8'd0;
                    if (w_row_last) begin
                        r_row      <= 8'd0;
                        r_state    <= ST_IDLE;
                        r_win_last <= 1'b1;
                    end else begin
                        r_row <= r_row + 8'd1;
                    end
                end else begin
                    r_col <= r_col + 8'd1;
                end
            end else if (start) begin
                if (w_cfg_ok) begin
                    r_state       <= ST_STREAM;
                    r_w           <= cfg_width;
                    r_h           <= cfg_height;
                    r_stage_width <= cfg_width;
                    r_row         <= 8'd0;
                    r_col         <= 8'd0;
                    r_underrun    <= 1'b0;
                    r_cfg_err     <= 1'b0;
                end else begin
                    r_cfg_err <= 1'b1;
                end
            end
        end
    end

    assign pix_if.in_ready = w_streaming;
    assign busy            = w_streaming;
    assign pix_out         = (w_streaming && pix_if.in_valid) ? pix_if.pixel_in : 8'd0;
    assign stage_width     = r_stage_width;
    assign win_valid       = r_win_valid;
    assign win_last        = r_win_last;
    assign done            = r_win_last;
    assign win_row         = r_win_row;
    assign win_col         = r_win_col;
    assign underrun        = r_underrun;
    assign cfg_err         = r_cfg_err;

endmodule
